// File: rtl/mux_pkg.sv
// Shared select encoding for the 4-to-1 mux primitive.
// Imported by the combinational core and the registered top.
`timescale 1ns/1ps
package mux_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } sel_t;

endpackage

// File: rtl/mux4_comb.sv
// Pure combinational 4-to-1 select; an unknown select yields all-X
// in simulation so X-propagation stays visible downstream.
`timescale 1ns/1ps
module mux4_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] s
);

    always_comb begin
        y = 'x;
        case (sel_t'(s))
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux4_behavioural.sv
// 4-to-1 mux with zero-latency output y plus an enabled register
// stage holding the result and the select that produced it.
`timescale 1ns/1ps
module mux4_behavioural
    import mux_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] s,
    input  logic             en,
    output logic [WIDTH-1:0] y_q,
    output logic [SEL_W-1:0] s_q
);

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .y (y),
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .s (s)
    );

    // Reset wins over en; y itself is never gated by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= RESET_VAL;
            s_q <= SEL_A;
        end else if (en) begin
            y_q <= y;
            s_q <= s;
        end
    end

endmodule

// File: tb/tb_mux4_behavioural.sv
// Directed and randomized checks of mux4_behavioural at WIDTH=1 and 8
// against a lookup-table model of the select and register rules.
`timescale 1ns/1ps
module tb_mux4_behavioural;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       y1, a1, b1, c1, d1, en1, yq1;
    logic [1:0] s1, sq1;

    // WIDTH=8 instance
    logic [7:0] y8, a8, b8, c8, d8, yq8;
    logic [1:0] s8, sq8;
    logic       en8;

    mux4_behavioural #(.WIDTH(1)) u_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y1),
        .a     (a1),
        .b     (b1),
        .c     (c1),
        .d     (d1),
        .s     (s1),
        .en    (en1),
        .y_q   (yq1),
        .s_q   (sq1)
    );

    mux4_behavioural #(.WIDTH(8), .RESET_VAL(8'h00)) u_w8 (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y8),
        .a     (a8),
        .b     (b8),
        .c     (c8),
        .d     (d8),
        .s     (s8),
        .en    (en8),
        .y_q   (yq8),
        .s_q   (sq8)
    );

    logic [7:0] tbl [4];
    logic [7:0] exp_yq;
    logic [1:0] exp_sq;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive8(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] vc, input logic [7:0] vd);
        tbl[0] = va; tbl[1] = vb; tbl[2] = vc; tbl[3] = vd;
        a8 = va; b8 = vb; c8 = vc; d8 = vd;
    endtask

    // Apply the register rules to the model, then advance past the edge.
    task automatic clock8();
        if (!rst_n) begin
            exp_yq = 8'h00;
            exp_sq = 2'd0;
        end else if (en8) begin
            exp_yq = tbl[s8];
            exp_sq = s8;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        rst_n = 1'b0;
        en1 = 1'b0; en8 = 1'b0;
        a1 = 0; b1 = 0; c1 = 0; d1 = 0; s1 = 0;
        drive8(8'h00, 8'h00, 8'h00, 8'h00);
        s8 = 2'd0;
        exp_yq = 8'hxx; exp_sq = 2'bxx;
        clock8();
        clock8();
        chk("reset_yq8", yq8, 8'h00);
        chk("reset_sq8", {6'd0, sq8}, 8'h00);
        chk("reset_yq1", {7'd0, yq1}, 8'h00);
        chk("reset_sq1", {6'd0, sq1}, 8'h00);
        rst_n = 1'b1;

        // Single set input, select swept
        a1 = 1; b1 = 0; c1 = 0; d1 = 0;
        for (int i = 0; i < 4; i++) begin
            s1 = 2'(i);
            #0.01;
            chk($sformatf("a_only_s%0d", i), {7'd0, y1},
                (i == 0) ? 8'h01 : 8'h00);
        end

        // Walking one over b, c, d
        for (int k = 1; k < 4; k++) begin
            pat = 4'b1000 >> k;
            {a1, b1, c1, d1} = pat;
            for (int i = 0; i < 4; i++) begin
                s1 = 2'(i);
                #0.01;
                chk($sformatf("walk%0d_s%0d", k, i), {7'd0, y1},
                    (i == k) ? 8'h01 : 8'h00);
            end
        end

        // Registered path
        drive8(8'h11, 8'h22, 8'h33, 8'h44);
        en8 = 1'b1; s8 = 2'd2;
        #0.01;
        chk("load_y", y8, 8'h33);
        clock8();
        chk("load_yq", yq8, 8'h33);
        chk("load_sq", {6'd0, sq8}, 8'h02);

        // Hold
        en8 = 1'b0; s8 = 2'd3;
        #0.01;
        chk("hold_y", y8, 8'h44);
        for (int i = 0; i < 3; i++) begin
            clock8();
            chk($sformatf("hold_yq%0d", i), yq8, 8'h33);
            chk($sformatf("hold_sq%0d", i), {6'd0, sq8}, 8'h02);
        end

        // Reset beats en; y keeps tracking
        rst_n = 1'b0; en8 = 1'b1; s8 = 2'd1;
        clock8();
        chk("rst_yq", yq8, 8'h00);
        chk("rst_sq", {6'd0, sq8}, 8'h00);
        chk("rst_y", y8, 8'h22);
        s8 = 2'd3;
        #0.01;
        chk("rst_y_track", y8, 8'h44);
        rst_n = 1'b1;
        clock8();
        chk("post_rst_yq", yq8, 8'h44);
        chk("post_rst_sq", {6'd0, sq8}, 8'h03);

        // Unknown select (only observable on 4-state simulators)
        en8 = 1'b0;
        s8 = 2'bxx;
        #0.01;
        if ($isunknown(s8))
            chk("sel_x_y", y8, 8'hxx);
        else
            chk("sel_x_y", y8, tbl[s8]);
        s8 = 2'd0;
        #0.01;
        chk("sel_x_restore", y8, 8'h11);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            drive8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            s8    = 2'($urandom_range(0, 3));
            en8   = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 9) != 0);
            #0.01;
            chk($sformatf("rnd%0d_y", n), y8, tbl[s8]);
            clock8();
            chk($sformatf("rnd%0d_yq", n), yq8, exp_yq);
            chk($sformatf("rnd%0d_sq", n), {6'd0, sq8}, {6'd0, exp_sq});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
